// File: rtl/lsu_mem_master_if.sv
`default_nettype none
// ============================================================================
// Module : lsu_mem_master_if
// Brief  : Core-request and data-memory signal bundle for the load/store unit.
// Rev    : 1.0
// ============================================================================
interface lsu_mem_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport master (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_read, mem_write, mem_address, mem_write_data
    );

    modport slave (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_read, mem_write, mem_address, mem_write_data
    );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module : lsu_mem_master
// Brief  : Single-outstanding load/store unit; sub-word stores use read-modify-write.
// Rev    : 1.0
// ============================================================================
module lsu_mem_master #(
    parameter int unsigned MEM_BYTES   = 1024,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  wire                   clk,
    input  wire                   reset,
    lsu_mem_master_if.master      bus
);

    localparam logic [1:0]  c_S_IDLE    = 2'd0;
    localparam logic [1:0]  c_S_READ    = 2'd1;
    localparam logic [1:0]  c_S_WRITE   = 2'd2;
    localparam logic [1:0]  c_S_RESP    = 2'd3;
    localparam logic [32:0] c_MEM_LIMIT = 33'(MEM_BYTES);

    logic [1:0]  state_q, state_d;
    logic        write_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rbuf_q;
    logic        err_q;

    logic [32:0] w_nbytes;
    logic [32:0] w_end_addr;
    logic        w_misaligned;
    logic        w_req_err;
    logic        w_accept;
    logic [31:0] w_load_data;
    logic        w_sext;

    // Request checks are evaluated on the live request so the IDLE branch can pick its target
    always_comb begin
        case (bus.req_size)
            2'b00:   w_nbytes = 33'd1;
            2'b01:   w_nbytes = 33'd2;
            default: w_nbytes = 33'd4;
        endcase
        w_end_addr   = {1'b0, bus.req_addr} + w_nbytes;
        w_misaligned = ((bus.req_size == 2'b01) & bus.req_addr[0]) |
                       ((bus.req_size == 2'b10) & (bus.req_addr[1:0] != 2'b00));
        w_req_err    = (bus.req_size == 2'b11) |
                       (CHECK_ALIGN & w_misaligned) |
                       (w_end_addr > c_MEM_LIMIT);
        w_accept     = (state_q == c_S_IDLE) & bus.req_valid;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= c_S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_S_IDLE: begin
                if (bus.req_valid) begin
                    if (w_req_err)
                        state_d = c_S_RESP;
                    else if (bus.req_write && (bus.req_size == 2'b10))
                        state_d = c_S_WRITE;
                    else
                        state_d = c_S_READ;
                end
            end
            c_S_READ:  state_d = write_q ? c_S_WRITE : c_S_RESP;
            c_S_WRITE: state_d = c_S_RESP;
            default:   state_d = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rbuf_q     <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            if (w_accept) begin
                write_q    <= bus.req_write;
                size_q     <= bus.req_size;
                unsigned_q <= bus.req_unsigned;
                addr_q     <= bus.req_addr;
                wdata_q    <= bus.req_wdata;
                err_q      <= w_req_err;
            end
            if (state_q == c_S_READ) begin
                rbuf_q <= bus.mem_read_data;
            end
        end
    end

    always_comb begin
        w_sext = ~unsigned_q;
        case (size_q)
            2'b00:   w_load_data = {{24{w_sext & rbuf_q[7]}},  rbuf_q[7:0]};
            2'b01:   w_load_data = {{16{w_sext & rbuf_q[15]}}, rbuf_q[15:0]};
            default: w_load_data = rbuf_q;
        endcase
    end

    // Reset gates req_ready so nothing looks acceptable while the block is held in reset
    always_comb begin
        bus.req_ready      = reset & (state_q == c_S_IDLE);
        bus.resp_valid     = 1'b0;
        bus.resp_rdata     = 32'd0;
        bus.resp_error     = 1'b0;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.mem_address    = 32'd0;
        bus.mem_write_data = 32'd0;
        case (state_q)
            c_S_READ: begin
                bus.mem_read    = 1'b1;
                bus.mem_address = addr_q;
            end
            c_S_WRITE: begin
                bus.mem_write   = 1'b1;
                bus.mem_address = addr_q;
                case (size_q)
                    2'b00:   bus.mem_write_data = {rbuf_q[31:8],  wdata_q[7:0]};
                    2'b01:   bus.mem_write_data = {rbuf_q[31:16], wdata_q[15:0]};
                    default: bus.mem_write_data = wdata_q;
                endcase
            end
            c_S_RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_error = err_q;
                bus.resp_rdata = (err_q | write_q) ? 32'd0 : w_load_data;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module : tb_lsu_mem_master
// Brief  : Directed self-checking bench for lsu_mem_master with a byte-array memory.
// Rev    : 1.0
// ============================================================================
module tb_lsu_mem_master;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    logic [7:0]  mem [0:1023];
    int          wr_cnt;
    int          rd_cnt;
    int          resp_cnt;
    logic [31:0] last_wdata;

    lsu_mem_master_if bus ();

    lsu_mem_master #(
        .MEM_BYTES   (1024),
        .CHECK_ALIGN (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] ra0, ra1, ra2, ra3;
    assign ra0 = bus.mem_address[9:0];
    assign ra1 = ra0 + 10'd1;
    assign ra2 = ra0 + 10'd2;
    assign ra3 = ra0 + 10'd3;
    assign bus.mem_read_data = {mem[ra3], mem[ra2], mem[ra1], mem[ra0]};

    // Memory commits on the falling edge of a mem_write cycle
    always @(negedge clk) begin
        if (bus.mem_write) begin
            mem[ra0] <= bus.mem_write_data[7:0];
            mem[ra1] <= bus.mem_write_data[15:8];
            mem[ra2] <= bus.mem_write_data[23:16];
            mem[ra3] <= bus.mem_write_data[31:24];
            last_wdata <= bus.mem_write_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (bus.mem_read)   rd_cnt   <= rd_cnt + 1;
        if (bus.resp_valid) resp_cnt <= resp_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] memw(input int a);
        return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    endfunction

    // Called #1 after a posedge with the LSU idle; returns #1 after the posedge following the response
    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic er);
        chk("ready_before_req", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_write    = w;
        bus.req_size     = sz;
        bus.req_unsigned = u;
        bus.req_addr     = a;
        bus.req_wdata    = d;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 99;
        rd  = 'x;
        er  = 1'bx;
        for (int k = 1; k <= 8; k++) begin
            if (bus.resp_valid) begin
                lat = k;
                rd  = bus.resp_rdata;
                er  = bus.resp_error;
                break;
            end
            @(posedge clk); #1;
        end
        chk("resp_seen", {31'd0, lat != 99}, 32'd1);
        @(posedge clk); #1;
        chk("resp_single_pulse", {31'd0, bus.resp_valid}, 32'd0);
    endtask

    int          lat;
    logic [31:0] rd;
    logic        er;
    int          wr0, rd0, rs0;
    logic [31:0] exp_q [3];
    int          acc_cyc [3];
    int          acc_idx, resp_idx, ready_cycles;
    logic        acc;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        wr_cnt = 0; rd_cnt = 0; resp_cnt = 0; last_wdata = 32'd0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        reset = 1'b0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;

        #2;
        chk("rst_req_ready",   {31'd0, bus.req_ready},  32'd0);
        chk("rst_resp_valid",  {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_mem_read",    {31'd0, bus.mem_read},   32'd0);
        chk("rst_mem_write",   {31'd0, bus.mem_write},  32'd0);
        chk("rst_mem_address", bus.mem_address,         32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        // Word store then load
        wr0 = wr_cnt; rd0 = rd_cnt;
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er);
        chk("wst_latency", 32'(lat), 32'd2);
        chk("wst_rdata",   rd, 32'd0);
        chk("wst_error",   {31'd0, er}, 32'd0);
        chk("wst_wr_cycles", 32'(wr_cnt - wr0), 32'd1);
        chk("wst_rd_cycles", 32'(rd_cnt - rd0), 32'd0);
        chk("wst_mem_bytes", {mem[16'h13], mem[16'h12], mem[16'h11], mem[16'h10]}, 32'hDEADBEEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er);
        chk("wld_latency", 32'(lat), 32'd2);
        chk("wld_rdata",   rd, 32'hDEADBEEF);

        // Byte store read-modify-write
        mem[32'h20] = 8'h44; mem[32'h21] = 8'h33; mem[32'h22] = 8'h22; mem[32'h23] = 8'h11;
        wr0 = wr_cnt; rd0 = rd_cnt;
        do_req(1'b1, 2'b00, 1'b0, 32'h20, 32'hFFFFFFAB, lat, rd, er);
        chk("bst_latency",   32'(lat), 32'd3);
        chk("bst_wdata",     last_wdata, 32'h112233AB);
        chk("bst_rd_cycles", 32'(rd_cnt - rd0), 32'd1);
        chk("bst_wr_cycles", 32'(wr_cnt - wr0), 32'd1);
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, rd, er);
        chk("bst_readback",  rd, 32'h112233AB);

        // Half store RMW at 0x22: old word 0x00001122 -> writes 0x00001234
        do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'hCDEF1234, lat, rd, er);
        chk("hst_latency",  32'(lat), 32'd3);
        chk("hst_wdata",    last_wdata, 32'h00001234);
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, rd, er);
        chk("hst_readback", rd, 32'h123433AB);

        // Sign / zero extension
        mem[32'h30] = 8'h80; mem[32'h34] = 8'h01; mem[32'h35] = 8'h80;
        do_req(1'b0, 2'b00, 1'b0, 32'h30, 32'h0, lat, rd, er);
        chk("lb_signed",   rd, 32'hFFFFFF80);
        do_req(1'b0, 2'b00, 1'b1, 32'h30, 32'h0, lat, rd, er);
        chk("lb_unsigned", rd, 32'h00000080);
        do_req(1'b0, 2'b01, 1'b0, 32'h34, 32'h0, lat, rd, er);
        chk("lh_signed",   rd, 32'hFFFF8001);
        do_req(1'b0, 2'b01, 1'b1, 32'h34, 32'h0, lat, rd, er);
        chk("lh_unsigned", rd, 32'h00008001);

        // Error requests: no memory activity, 1-cycle latency
        wr0 = wr_cnt; rd0 = rd_cnt;
        do_req(1'b0, 2'b01, 1'b0, 32'h41, 32'h0, lat, rd, er);
        chk("err_misalign_lat", 32'(lat), 32'd1);
        chk("err_misalign_flag", {31'd0, er}, 32'd1);
        chk("err_misalign_rdata", rd, 32'd0);
        do_req(1'b1, 2'b11, 1'b0, 32'h40, 32'h55, lat, rd, er);
        chk("err_size_lat",  32'(lat), 32'd1);
        chk("err_size_flag", {31'd0, er}, 32'd1);
        do_req(1'b0, 2'b10, 1'b0, 32'h3FE, 32'h0, lat, rd, er);
        chk("err_word3fe_flag", {31'd0, er}, 32'd1);
        chk("err_word3fe_rdata", rd, 32'd0);
        do_req(1'b1, 2'b00, 1'b0, 32'h400, 32'h77, lat, rd, er);
        chk("err_range_flag", {31'd0, er}, 32'd1);
        chk("err_no_mem_wr", 32'(wr_cnt - wr0), 32'd0);
        chk("err_no_mem_rd", 32'(rd_cnt - rd0), 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, lat, rd, er);
        chk("edge_3fc_flag",  {31'd0, er}, 32'd0);
        chk("edge_3fc_lat",   32'(lat), 32'd2);

        // Three requests with req_valid held continuously
        exp_q[0] = 32'hDEADBEEF; exp_q[1] = 32'h00000080; exp_q[2] = 32'h123433AB;
        acc_idx = 0; resp_idx = 0; ready_cycles = 0;
        bus.req_valid = 1'b1; bus.req_write = 1'b0;
        bus.req_size = 2'b10; bus.req_unsigned = 1'b0; bus.req_addr = 32'h10;
        for (int cyc = 0; cyc < 20; cyc++) begin
            acc = bus.req_valid & bus.req_ready;
            if (bus.req_ready && bus.req_valid) ready_cycles++;
            if (bus.resp_valid) begin
                if (resp_idx < 3) chk("b2b_resp_data", bus.resp_rdata, exp_q[resp_idx]);
                resp_idx++;
            end
            @(posedge clk); #1;
            if (acc) begin
                acc_cyc[acc_idx] = cyc;
                acc_idx++;
                if (acc_idx == 1) begin
                    bus.req_size = 2'b00; bus.req_unsigned = 1'b1; bus.req_addr = 32'h30;
                end else if (acc_idx == 2) begin
                    bus.req_size = 2'b10; bus.req_unsigned = 1'b0; bus.req_addr = 32'h20;
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
        end
        chk("b2b_accepts",     32'(acc_idx), 32'd3);
        chk("b2b_responses",   32'(resp_idx), 32'd3);
        chk("b2b_ready_cycles", 32'(ready_cycles), 32'd3);
        if (acc_idx == 3) begin
            chk("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
            chk("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
        end

        // Reset during the WRITE cycle of a word store
        wr0 = wr_cnt; rs0 = resp_cnt;
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b10;
        bus.req_addr = 32'h50; bus.req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("abort_in_write", {31'd0, bus.mem_write}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("abort_mem_write", {31'd0, bus.mem_write},  32'd0);
        chk("abort_mem_addr",  bus.mem_address,         32'd0);
        chk("abort_mem_wdata", bus.mem_write_data,      32'd0);
        chk("abort_req_ready", {31'd0, bus.req_ready},  32'd0);
        chk("abort_resp",      {31'd0, bus.resp_valid}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_no_write",  32'(wr_cnt - wr0), 32'd0);
        chk("abort_mem50",     memw(32'h50), 32'd0);
        chk("abort_no_resp",   32'(resp_cnt - rs0), 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er);
        chk("post_rst_lat",   32'(lat), 32'd2);
        chk("post_rst_rdata", rd, 32'hDEADBEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store unit that drives the byte-addressable data memory as its initiator.
- Accepts one load or store request at a time from the core over a valid/ready handshake.
- Generates mem_read/mem_write/address/write_data toward the memory. Sub-word stores use read-modify-write, because the memory always writes 4 bytes at address..address+3.
- Returns sign- or zero-extended load data with a single-cycle response pulse.

Parameters:
MEM_BYTES, 1024, memory size in bytes; accesses beyond it are errors
CHECK_ALIGN, 1, 1 = halfword needs addr[0]=0 and word needs addr[1:0]=0; 0 = no alignment check

Ports:
clk  in  1  system clock; all state updates on posedge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  core presents a request
req_ready  out  1  LSU can accept a request
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_error  out  1  qualified by resp_valid; illegal size, misaligned or out of range
mem_read  out  1  read strobe to data memory
mem_write  out  1  write strobe to data memory; memory commits at negedge of the same cycle
mem_address  out  32  byte address to memory
mem_write_data  out  32  word to memory, little-endian (byte 0 at address)
mem_read_data  in  32  combinational read data from memory

Behaviour:
- Reset: async; while reset=0, state is IDLE and every output is 0, including req_ready. Latched request and read buffer are cleared.
- States: IDLE, READ, WRITE, RESP.
- All memory-side outputs decode from the state register only (Moore). Outside READ/WRITE, mem_read=mem_write=0 and mem_address=mem_write_data=0.
- IDLE:
  - req_ready=1.
  - On posedge with req_valid=1: latch write, size, unsigned, addr, wdata.
  - Compute error = (size==11) | (CHECK_ALIGN & misaligned) | (addr + nbytes > MEM_BYTES). Use a 33-bit add; nbytes is 1/2/4.
  - Next state: error -> RESP; load -> READ; word store -> WRITE; byte/half store -> READ.
- READ:
  - mem_read=1, mem_address=latched addr.
  - At posedge, mem_read_data is captured into rbuf.
  - Next state: load -> RESP; store -> WRITE.
- WRITE:
  - mem_write=1, mem_address=latched addr.
  - mem_write_data: word = wdata; half = {rbuf[31:16], wdata[15:0]}; byte = {rbuf[31:8], wdata[7:0]}.
  - Next state: RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; next state IDLE. No response backpressure.
  - resp_rdata for loads: byte = rbuf[7:0] extended; half = rbuf[15:0] extended; word = rbuf.
  - resp_rdata=0 and resp_error=0 for successful stores. On error: resp_error=1, resp_rdata=0.
- req_ready=0 in READ, WRITE and RESP. A request held valid in those states is not accepted until IDLE.
- Latency from the accepting posedge to the cycle resp_valid is high:
  - error: 1 cycle
  - load: 2 cycles
  - word store: 2 cycles
  - byte/half store: 3 cycles
  - Back-to-back throughput is one request per (latency+1) cycles.
- Error requests never assert mem_read or mem_write.
- Reset asserted mid-operation: the operation is aborted immediately. If reset falls during WRITE before the negedge, mem_write drops asynchronously and no memory write occurs. No resp_valid is produced for the aborted request.
- With CHECK_ALIGN=0, unaligned accesses pass straight through with the same byte ordering as aligned ones.

Test Plan:
- Word store 0xDEADBEEF @0x10, then word load @0x10 -> mem_write high exactly 1 cycle; resp_rdata=0xDEADBEEF 2 cycles after accept; mem bytes 0x10..0x13 = EF,BE,AD,DE.
- Preload @0x20 = 0x11223344; byte store 0xAB @0x20 -> READ then WRITE cycle with mem_write_data=0x112233AB; a subsequent word load returns 0x112233AB; resp_valid 3 cycles after accept.
- Byte @0x30 = 0x80: signed byte load -> 0xFFFFFF80; unsigned -> 0x00000080. Half 0x8001: signed -> 0xFFFF8001.
- Half load @0x41 with CHECK_ALIGN=1 -> resp_valid+resp_error 1 cycle after accept, resp_rdata=0, mem_read/mem_write never high. Same checks for size=11, and for word @0x3FE with MEM_BYTES=1024.
- Hold req_valid continuously with 3 queued requests -> req_ready low outside IDLE; each request accepted only in IDLE; responses arrive in order.
- Assert reset during the WRITE state of a word store to @0x50 (before negedge) -> memory @0x50 unchanged, no resp_valid, all outputs 0. After release req_ready=1 and a new load completes normally.
